// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory built-in self test.
// Holds the FSM state encoding and the default memory geometry.
package data_mem_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_A = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/bist_addr_counter.sv
// Address counter that walks the whole memory once per BIST phase.
// The terminal flag marks the last address, so the next enabled edge wraps to zero.
module bist_addr_counter #(
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         enable,
    output logic [A-1:0] count,
    output logic         terminal
);

    // A clear request overrides counting.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + A'(1);
        end
    end

    assign terminal = &count;

endmodule

// File: rtl/data_mem_bist.sv
// March-style BIST for a data memory.
// Writes addr^seed to every location, then reads each location back and counts mismatches.
module data_mem_bist
    import data_mem_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int A = DEF_A
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic [W-1:0] Seed,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic         Busy,
    output logic         Done,
    output logic         Pass,
    output logic [A:0]   ErrCount,
    output logic         FirstErrValid,
    output logic [A-1:0] FirstErrAddr
);

    localparam logic [A:0] ERR_ONE = (A+1)'(1);

    bist_state_t state;
    bist_state_t state_next;

    logic [W-1:0] seed_q;
    logic [A-1:0] cnt;
    logic         cnt_last;
    logic         cnt_clear;
    logic         cnt_en;
    logic         start_run;
    logic         compare_en;
    logic         finish_run;
    logic         abort_run;
    logic [W-1:0] expected;
    logic         mismatch;
    logic         done_q;
    logic [A:0]   err_count_q;
    logic         first_err_valid_q;
    logic [A-1:0] first_err_addr_q;

    bist_addr_counter #(
        .A(A)
    ) u_addr_counter (
        .clk     (clk),
        .Reset   (Reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (cnt),
        .terminal(cnt_last)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort is checked before the end-of-phase test so it always wins.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        start_run  = 1'b0;
        compare_en = 1'b0;
        finish_run = 1'b0;
        abort_run  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_next = WRITE;
                    cnt_clear  = 1'b1;
                    start_run  = 1'b1;
                end
            end
            WRITE: begin
                if (Abort) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                    abort_run  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (Abort) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                    abort_run  = 1'b1;
                end else begin
                    cnt_en     = 1'b1;
                    compare_en = 1'b1;
                    if (cnt_last) begin
                        state_next = DONE;
                        finish_run = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign expected = W'(cnt) ^ seed_q;
    assign mismatch = (MemDataOut != expected);

    // Error bookkeeping; A+1 bits can hold a mismatch on every address, so no saturation.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            seed_q            <= '0;
            done_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
        end else if (start_run) begin
            seed_q            <= Seed;
            done_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
        end else begin
            if (compare_en && mismatch) begin
                err_count_q <= err_count_q + ERR_ONE;
                if (!first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_addr_q  <= cnt;
                end
            end
            if (finish_run) begin
                done_q <= 1'b1;
            end
            if (abort_run) begin
                done_q <= 1'b0;
            end
        end
    end

    assign Busy          = (state == WRITE) || (state == READ);
    assign MemWriteEn    = (state == WRITE);
    assign MemAddress    = Busy ? cnt : '0;
    assign MemDataIn     = (state == WRITE) ? expected : '0;
    assign Done          = done_q;
    assign Pass          = done_q && (err_count_q == '0);
    assign ErrCount      = err_count_q;
    assign FirstErrValid = first_err_valid_q;
    assign FirstErrAddr  = first_err_addr_q;

endmodule

// File: tb/tb_data_mem_bist.sv
// Directed bench for data_mem_bist with a behavioural data memory and read-fault injection.
// Expected run results are queued at Start and popped when Done rises.
module tb_data_mem_bist;

    typedef struct {
        logic       pass;
        logic [8:0] err;
        logic       fev;
        logic [7:0] fea;
    } result_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] seed;
    logic       mem_write_en;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       first_err_valid;
    logic [7:0] first_err_addr;

    logic [7:0] mem [256];
    bit         flt [256];
    int         wr_total = 0;
    int         rd_total = 0;
    logic [7:0] last_wr_addr = 8'h00;

    int         total = 0;
    int         bad = 0;
    int         wr0;
    int         rd0;
    result_t    sb_q[$];

    data_mem_bist #(
        .W(8),
        .A(8)
    ) dut (
        .clk          (clk),
        .Reset        (rst_n),
        .Start        (start),
        .Abort        (abort),
        .Seed         (seed),
        .MemWriteEn   (mem_write_en),
        .MemAddress   (mem_address),
        .MemDataIn    (mem_data_in),
        .MemDataOut   (mem_data_out),
        .Busy         (busy),
        .Done         (done),
        .Pass         (pass),
        .ErrCount     (err_count),
        .FirstErrValid(first_err_valid),
        .FirstErrAddr (first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory with combinational read; flagged addresses read back as zero.
    assign mem_data_out = flt[mem_address] ? 8'h00 : mem[mem_address];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_address] <= mem_data_in;
            wr_total         <= wr_total + 1;
            last_wr_addr     <= mem_address;
        end
        if (busy && !mem_write_en) begin
            rd_total <= rd_total + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start_v, input logic abort_v, input logic [7:0] seed_v);
        @(negedge clk);
        start = start_v;
        abort = abort_v;
        seed  = seed_v;
    endtask

    task automatic run_start(input logic [7:0] seed_v);
        applyStimulus(1'b1, 1'b0, seed_v);
        wr0 = wr_total;
        rd0 = rd_total;
        applyStimulus(1'b0, 1'b0, seed_v);
        checkOutput("first_write", {busy, mem_write_en, mem_address, mem_data_in, done},
                    {1'b1, 1'b1, 8'h00, seed_v, 1'b0});
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        result_t e;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_pass"}, 64'(pass), 64'(e.pass));
            checkOutput({tag, "_errcount"}, 64'(err_count), 64'(e.err));
            checkOutput({tag, "_fev"}, 64'(first_err_valid), 64'(e.fev));
            checkOutput({tag, "_fea"}, 64'(first_err_addr), 64'(e.fea));
        end
        checkOutput({tag, "_idle_bus"}, {busy, mem_write_en, mem_address, mem_data_in}, 64'd0);
        checkOutput({tag, "_wr_cycles"}, 64'(wr_total - wr0), 64'd256);
        checkOutput({tag, "_rd_cycles"}, 64'(rd_total - rd0), 64'd256);
    endtask

    task automatic check_mem(input string tag, input logic [7:0] seed_v);
        int bad_cells;
        logic [7:0] ia;
        bad_cells = 0;
        for (int i = 0; i < 256; i++) begin
            ia = i[7:0];
            if (mem[i] !== (ia ^ seed_v)) bad_cells++;
        end
        checkOutput({tag, "_mem_image"}, 64'(bad_cells), 64'd0);
    endtask

    task automatic wait_addr(input logic want_write, input logic [7:0] addr, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && mem_write_en === want_write && mem_address === addr) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_reached"}, 64'(ok), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed  = 8'h00;
        for (int i = 0; i < 256; i++) flt[i] = 1'b0;

        #3;
        checkOutput("reset_outputs",
                    {mem_write_en, mem_address, mem_data_in, busy, done, pass,
                     err_count, first_err_valid, first_err_addr}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean run, seed AA");
        sb_q.push_back('{pass: 1'b1, err: 9'd0, fev: 1'b0, fea: 8'h00});
        run_start(8'hAA);
        wait_done("clean_aa");
        check_mem("clean_aa", 8'hAA);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("done_hold", {done, pass, busy, err_count}, {1'b1, 1'b1, 1'b0, 9'd0});

        $display("[TB] restart from DONE with seed 55, Start re-pulsed in WRITE");
        sb_q.push_back('{pass: 1'b1, err: 9'd0, fev: 1'b0, fea: 8'h00});
        run_start(8'h55);
        checkOutput("restart_cleared", {done, pass, err_count}, 64'd0);
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h33);
        applyStimulus(1'b0, 1'b0, 8'h33);
        checkOutput("ignored_start_addr", 64'(mem_address), 64'd12);
        wait_done("reseed_55");
        check_mem("reseed_55", 8'h55);

        $display("[TB] read faults at 05 and 10, seed 01");
        flt[8'h05] = 1'b1;
        flt[8'h10] = 1'b1;
        sb_q.push_back('{pass: 1'b0, err: 9'd2, fev: 1'b1, fea: 8'h05});
        run_start(8'h01);
        wait_done("fault_two");
        flt[8'h05] = 1'b0;
        flt[8'h10] = 1'b0;

        $display("[TB] read fault at last address only, seed 3C");
        flt[8'hFF] = 1'b1;
        sb_q.push_back('{pass: 1'b0, err: 9'd1, fev: 1'b1, fea: 8'hFF});
        run_start(8'h3C);
        wait_done("fault_last");
        flt[8'hFF] = 1'b0;

        $display("[TB] abort at write address 40");
        run_start(8'h77);
        wait_addr(1'b1, 8'h40, "abort_wr");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_state", {mem_write_en, busy, done, mem_address},
                    {1'b0, 1'b0, 1'b0, 8'h00});
        repeat (3) @(negedge clk);
        checkOutput("abort_wr_count", 64'(wr_total - wr0), 64'd65);
        checkOutput("abort_last_addr", 64'(last_wr_addr), 64'h40);

        $display("[TB] reset during READ at address 80");
        run_start(8'h12);
        wait_addr(1'b0, 8'h80, "reset_rd");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs",
                    {mem_write_en, mem_address, mem_data_in, busy, done, pass,
                     err_count, first_err_valid, first_err_addr}, 64'd0);
        wr0 = wr_total;
        repeat (3) @(negedge clk);
        checkOutput("reset_no_writes", 64'(wr_total - wr0), 64'd0);
        rst_n = 1'b1;
        sb_q.push_back('{pass: 1'b1, err: 9'd0, fev: 1'b0, fea: 8'h00});
        run_start(8'h12);
        wait_done("after_reset");
        check_mem("after_reset", 8'h12);

        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
